control_sequencer: RTL and testbench
====================================

Name: control_sequencer

Overview:
- Hardwired Moore control unit for the Phase-1 Mini-SRC datapath; sits directly upstream of `datapath` and replaces the bench-driven control signals.
- Steps fetch (T0-T2) and execute (T3-T6) for register-register ALU, mul/div, neg/not, nop and halt.
- Decodes the IR contents returned by the datapath into one-hot register enables and an ALU_Control code.

Parameters:
- `NUM_REGS`, 16, number of general registers; sets the width of R_in and R_out.
- `ALU_W`, 5, width of ALU_Control.

Ports:
- `clock` in 1: system clock; all state changes on its rising edge.
- `clear` in 1: asynchronous, active-low reset; clear=0 resets immediately.
- `IR` in 32: instruction register contents from the datapath.
  - opcode = IR[31:27], ra = IR[26:23], rb = IR[22:19], rc = IR[18:15].
- `stop` in 1: halt request; level sensitive.
- `R_in` out 16: one-hot register load enables. Bit n drives Rnin.
- `R_out` out 16: one-hot register bus drive. Bit n drives Rnout.
- `PCout`, `PCin`, `IncPC`, `MARin`, `Read`, `MDRin`, `MDRout`, `IRin`, `Yin`, `Zin`, `Zlowout`, `Zhighout`, `HIin`, `LOin` out 1 each: datapath strobes of the same names.
- `ALU_Control` out 5: ALU operation select.
- `Run` out 1: 1 while executing; 0 in HALTED and during reset.

Behaviour:
- States: RST, T0, T1, T2, T3, T4, T5, T6, HALTED. State register is async-cleared to RST.
- All outputs are decoded from the state register and IR only (Moore, no input-to-output paths except IR). Every output is 0 in RST and HALTED.
- RST -> T0 on the first rising edge after clear returns to 1. Run=1 in T0..T6.
- Fetch:
  - T0: PCout, MARin, IncPC, Zin.
  - T1: Zlowout, PCin, Read, MDRin.
  - T2: MDRout, IRin.
- IR is valid from T3 onward. The T2 exit branch uses the IR value present at that edge.
- Opcodes and ALU_Control values:
  - add 00010 -> ALU_Control 00000; sub 00011 -> 00001; and 00100 -> 00010; or 00101 -> 00011.
  - shr 00110 -> 00100; shra 00111 -> 00101; shl 01000 -> 00110; ror 01001 -> 00111; rol 01010 -> 01000.
  - mul 01111 -> 01101; div 10000 -> 01110; neg 10001 -> 01111; not 10010 -> 10000.
  - nop 11010; halt 11011.
  - Rule: ALU_Control = opcode - 2. It is driven only in the state that asserts Zin for execute; 0 elsewhere.
- Three-operand ALU ops (add..rol):
  - T3: R_out[rb], Yin.
  - T4: R_out[rc], ALU_Control, Zin.
  - T5: Zlowout, R_in[ra]. Next state T0.
- mul/div:
  - T3: R_out[ra], Yin.
  - T4: R_out[rb], ALU_Control, Zin.
  - T5: Zlowout, LOin.
  - T6: Zhighout, HIin. Next state T0.
- neg/not:
  - T3: R_out[rb], ALU_Control, Zin.
  - T4: Zlowout, R_in[ra]. Next state T0.
- nop and any undefined opcode: T2 -> T0, no execute states.
- halt: T2 -> HALTED.
- R_out and R_in are exactly one-hot when active and all-zero otherwise. Register index 0 is treated like any other.
- stop:
  - Sampled only at the edge leaving the last execute state (or T2 for nop).
  - If stop=1 there, go to HALTED instead of T0.
  - A stop pulse that falls before that edge is ignored; an in-flight instruction always completes.
- HALTED is sticky; only clear=0 exits it.
- clear=0 mid-instruction: state returns to RST asynchronously; all strobes drop within the same delta and no partial register write may occur on the next edge.
- Simultaneous clear=0 and clock edge: reset wins.

Test Plan:
- Reset, then IR=32'h112B0000 (add R2,R5,R6) presented at T2, with R5=0x34 and R6=0x45 preloaded.
  - T3 R_out=16'h0020 with Yin; T4 R_out=16'h0040, ALU_Control=0, Zin; T5 R_in=16'h0004, Zlowout.
  - R2=0x79. Next state T0.
- mul R3,R4 (IR=32'h79A00000), R3=6, R4=7.
  - T5 LOin; T6 HIin.
  - LO=42, HI=0. Exactly 7 cycles T0..T6.
- not R1,R2 (opcode 10010) with R2=0: completes in T0..T4, R1=0xFFFFFFFF, ALU_Control=10000 only in T3.
- IR opcode 11111 (undefined): T0,T1,T2,T0 sequence; R_in and R_out never nonzero.
- halt opcode; separately, stop=1 asserted in T4 of an add.
  - Both: HALTED reached, Run=0, all outputs 0 for 10 cycles; add result still written in T5.
- clear=0 pulsed mid-T4.
  - All outputs 0 immediately; no R_in pulse.
  - After release: RST then T0 on the next edges, Run=1.

Source files
------------

// File: rtl/control_sequencer.sv
// control_sequencer: hardwired Moore control unit stepping fetch and execute for the Mini-SRC datapath.
module control_sequencer #(
    parameter int NUM_REGS = 16,
    parameter int ALU_W = 5
) (
    input  logic                clock,
    input  logic                clear,
    input  logic [31:0]         IR,
    input  logic                stop,
    output logic [NUM_REGS-1:0] R_in,
    output logic [NUM_REGS-1:0] R_out,
    output logic                PCout,
    output logic                PCin,
    output logic                IncPC,
    output logic                MARin,
    output logic                Read,
    output logic                MDRin,
    output logic                MDRout,
    output logic                IRin,
    output logic                Yin,
    output logic                Zin,
    output logic                Zlowout,
    output logic                Zhighout,
    output logic                HIin,
    output logic                LOin,
    output logic [ALU_W-1:0]    ALU_Control,
    output logic                Run
);
    typedef enum logic [3:0] {RST, T0, T1, T2, T3, T4, T5, T6, HALTED} state_t;
    localparam logic [NUM_REGS-1:0] ONE = 1;
    state_t state, next, fin;
    logic [4:0] op;
    logic alu3, muldiv, unary, halt;
    logic [NUM_REGS-1:0] ra_oh, rb_oh, rc_oh;
    logic [ALU_W-1:0] alu_op;
    logic ir_unused;
    assign op = IR[31:27];
    assign alu3 = op >= 5'd2 && op <= 5'd10;
    assign muldiv = op == 5'd15 || op == 5'd16;
    assign unary = op == 5'd17 || op == 5'd18;
    assign halt = op == 5'd27;
    assign ra_oh = ONE << IR[26:23];
    assign rb_oh = ONE << IR[22:19];
    assign rc_oh = ONE << IR[18:15];
    assign alu_op = ALU_W'(op - 5'd2);
    assign ir_unused = ^IR[14:0];
    // stop only matters at the edge that would otherwise return to T0
    assign fin = stop ? HALTED : T0;
    assign Run = state != RST && state != HALTED;

    always_ff @(posedge clock or negedge clear)
        if (!clear) state <= RST;
        else state <= next;

    always_comb begin
        next = state;
        {R_in, R_out, PCout, PCin, IncPC, MARin, Read, MDRin, MDRout, IRin,
         Yin, Zin, Zlowout, Zhighout, HIin, LOin, ALU_Control} = '0;
        case (state)
            RST: next = T0;
            T0: begin
                next = T1;
                {PCout, MARin, IncPC, Zin} = '1;
            end
            T1: begin
                next = T2;
                {Zlowout, PCin, Read, MDRin} = '1;
            end
            T2: begin
                next = halt ? HALTED : (alu3 || muldiv || unary) ? T3 : fin;
                {MDRout, IRin} = '1;
            end
            T3: begin
                next = T4;
                R_out = muldiv ? ra_oh : rb_oh;
                Yin = !unary;
                Zin = unary;
                ALU_Control = unary ? alu_op : '0;
            end
            T4: begin
                next = unary ? fin : T5;
                R_out = unary ? '0 : muldiv ? rb_oh : rc_oh;
                R_in = unary ? ra_oh : '0;
                Zlowout = unary;
                Zin = !unary;
                ALU_Control = unary ? '0 : alu_op;
            end
            T5: begin
                next = muldiv ? T6 : fin;
                Zlowout = 1'b1;
                LOin = muldiv;
                R_in = muldiv ? '0 : ra_oh;
            end
            T6: begin
                next = fin;
                {Zhighout, HIin} = '1;
            end
            default: next = HALTED;
        endcase
    end
endmodule

// File: tb/tb_control_sequencer.sv
// tb_control_sequencer: directed scoreboard bench comparing every cycle's control strobes.
module tb_control_sequencer;
    logic clock = 0, clear = 1, stop = 0;
    logic [31:0] IR = 0;
    logic [15:0] R_in, R_out;
    logic PCout, PCin, IncPC, MARin, Read, MDRin, MDRout, IRin;
    logic Yin, Zin, Zlowout, Zhighout, HIin, LOin, Run;
    logic [4:0] ALU_Control;
    int errors = 0, checks = 0;

    typedef struct packed {
        logic run;
        logic [15:0] rin, rout;
        logic pcout, pcin, incpc, marin, read, mdrin, mdrout, irin;
        logic yin, zin, zlo, zhi, hiin, loin;
        logic [4:0] alu;
    } obs_t;
    obs_t obs, q[$];

    control_sequencer dut (
        .clock(clock), .clear(clear), .IR(IR), .stop(stop),
        .R_in(R_in), .R_out(R_out), .PCout(PCout), .PCin(PCin), .IncPC(IncPC),
        .MARin(MARin), .Read(Read), .MDRin(MDRin), .MDRout(MDRout), .IRin(IRin),
        .Yin(Yin), .Zin(Zin), .Zlowout(Zlowout), .Zhighout(Zhighout), .HIin(HIin),
        .LOin(LOin), .ALU_Control(ALU_Control), .Run(Run)
    );

    always #5 clock = ~clock;

    assign obs = '{run: Run, rin: R_in, rout: R_out, pcout: PCout, pcin: PCin,
                   incpc: IncPC, marin: MARin, read: Read, mdrin: MDRin, mdrout: MDRout,
                   irin: IRin, yin: Yin, zin: Zin, zlo: Zlowout, zhi: Zhighout,
                   hiin: HIin, loin: LOin, alu: ALU_Control};

    task automatic chk(input obs_t e, input string tag);
        checks++;
        assert (obs === e) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, e);
        end
    endtask

    // Expected per-cycle outputs of one instruction; sk/sl describe the stop level
    function automatic void push_instr(logic [31:0] ir, int sk, int sl);
        logic [4:0] op = ir[31:27];
        logic [15:0] ra = 16'd1 << ir[26:23];
        logic [15:0] rb = 16'd1 << ir[22:19];
        logic [15:0] rc = 16'd1 << ir[18:15];
        int base = q.size();
        int last;
        bit halted;
        obs_t v;
        v = '0; v.run = 1; v.pcout = 1; v.marin = 1; v.incpc = 1; v.zin = 1; q.push_back(v);
        v = '0; v.run = 1; v.zlo = 1; v.pcin = 1; v.read = 1; v.mdrin = 1; q.push_back(v);
        v = '0; v.run = 1; v.mdrout = 1; v.irin = 1; q.push_back(v);
        if (op >= 2 && op <= 10) begin
            v = '0; v.run = 1; v.rout = rb; v.yin = 1; q.push_back(v);
            v = '0; v.run = 1; v.rout = rc; v.alu = op - 5'd2; v.zin = 1; q.push_back(v);
            v = '0; v.run = 1; v.zlo = 1; v.rin = ra; q.push_back(v);
        end else if (op == 15 || op == 16) begin
            v = '0; v.run = 1; v.rout = ra; v.yin = 1; q.push_back(v);
            v = '0; v.run = 1; v.rout = rb; v.alu = op - 5'd2; v.zin = 1; q.push_back(v);
            v = '0; v.run = 1; v.zlo = 1; v.loin = 1; q.push_back(v);
            v = '0; v.run = 1; v.zhi = 1; v.hiin = 1; q.push_back(v);
        end else if (op == 17 || op == 18) begin
            v = '0; v.run = 1; v.rout = rb; v.alu = op - 5'd2; v.zin = 1; q.push_back(v);
            v = '0; v.run = 1; v.zlo = 1; v.rin = ra; q.push_back(v);
        end
        last = q.size() - base - 1;
        halted = op == 27 || (sk >= 0 && last >= sk && (sl == 0 || last < sk + sl));
        if (halted) repeat (10) q.push_back('0);
    endfunction

    task automatic do_reset(input string tag);
        clear = 0;
        stop = 0;
        #1 chk('0, {tag, "_rst_async"});
        @(negedge clock);
        chk('0, {tag, "_rst_hold"});
        clear = 1;
    endtask

    task automatic run(input logic [31:0] ir, input string tag, input int sk = -1,
                       input int sl = 0, input int ck = -1);
        int n;
        push_instr(ir, sk, sl);
        n = q.size();
        for (int k = 0; k < n; k++) begin
            @(negedge clock);
            chk(q.pop_front(), $sformatf("%s[%0d]", tag, k));
            if (k == 2) IR = ir;
            if (k == sk) stop = 1;
            if (sl > 0 && k == sk + sl) stop = 0;
            if (k == ck) begin
                #2;
                q.delete();
                do_reset(tag);
                return;
            end
        end
    endtask

    initial begin
        #2 do_reset("init");
        run(32'h112B0000, "add");
        run(32'h79A00000, "mul");
        run({5'b10010, 4'd1, 4'd2, 19'd0}, "not");
        run({5'b11111, 27'd0}, "undef");
        run({5'b10000, 4'd7, 4'd8, 19'd0}, "div");
        run({5'b10001, 4'd0, 4'd15, 19'd0}, "neg_r0");
        run({5'b01000, 4'd15, 4'd0, 4'd9, 15'd0}, "shl");
        run(32'h112B0000, "add_pulse", 3, 1);
        run({5'b11010, 27'd0}, "nop");
        run({5'b11011, 27'd0}, "halt");
        do_reset("halt");
        run(32'h112B0000, "add_stop", 4, 0);
        do_reset("stop");
        run(32'h112B0000, "add_clr", -1, 0, 4);
        run({5'b01001, 4'd3, 4'd4, 4'd5, 15'd0}, "ror_after_clr");
        run({5'b11010, 27'd0}, "nop_stop", 2, 0);
        do_reset("nop_stop");
        run(32'h79A00000, "mul_again");
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
